// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding, MDU latency defaults and exception vector for pipe_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_BUSY   = 2'd1,
        EXC_FLUSH = 2'd2
    } state_t;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    function automatic int cnt_w(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: multiply/divide busy counter; loads the op latency, counts down to zero and holds there.
module md_busy_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int W        = cnt_w(MULT_CYC, DIV_CYC)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         isdiv,
    output logic [W-1:0] cnt,
    output logic         busy
);

    assign busy = |cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= isdiv ? W'(DIV_CYC) : W'(MULT_CYC);
        else if (busy)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/flush controller (load-use stall, exception/eret flush to EXC_VEC/EPC).
// Define PIPE_CTRL_MDU_STALL_EN to add the MD_BUSY state and multiply/divide busy stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic [4:0] waE,
    input  logic       memReadE,
    input  logic       md_startE,
    input  logic       md_isdivE,
    input  logic       md_useD,
    input  logic       excReqM,
    input  logic       eretM,
    output logic       stallF,
    output logic       stallD,
    output logic       clrE,
    output logic       DEMWclr,
    output logic       pcSelExc,
    output logic       pcSelEpc
);

    localparam int CW = cnt_w(MULT_CYC, DIV_CYC);

    state_t state, state_nxt;
    logic   exc, eret, flush, lu, md_stall, stall;

    assign exc   = excReqM;
    assign eret  = eretM && !excReqM;
    assign flush = exc || eret;
    assign lu    = memReadE && waE != 5'd0 && ((useRsD && rsD == waE) || (useRtD && rtD == waE));

`ifdef PIPE_CTRL_MDU_STALL_EN
    logic          accept, busy;
    logic [CW-1:0] cnt;
    logic          unused_ok;

    // A start alongside a flush belongs to an instruction being squashed.
    assign accept    = md_startE && state != MD_BUSY && !flush;
    assign md_stall  = md_useD && (state == MD_BUSY || md_startE);
    assign unused_ok = ^{EXC_VEC};

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .W        (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .isdiv (md_isdivE),
        .cnt   (cnt),
        .busy  (busy)
    );

    always_comb begin
        state_nxt = flush ? EXC_FLUSH : (accept || (busy && cnt != CW'(1))) ? MD_BUSY : RUN;
    end
`else
    logic unused_ok;

    assign md_stall  = 1'b0;
    assign unused_ok = ^{md_startE, md_isdivE, md_useD, EXC_VEC, state, CW > 0};

    always_comb begin
        state_nxt = flush ? EXC_FLUSH : RUN;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        stall    = !rst && !flush && (md_stall || lu);
        stallF   = stall;
        stallD   = stall;
        clrE     = stall;
        DEMWclr  = !rst && flush;
        pcSelExc = !rst && exc;
        pcSelEpc = !rst && eret;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rsD = '0, rtD = '0, waE = '0;
    logic       useRsD = 0, useRtD = 0, memReadE = 0;
    logic       md_startE = 0, md_isdivE = 0, md_useD = 0;
    logic       excReqM = 0, eretM = 0;
    logic       stallF, stallD, clrE, DEMWclr, pcSelExc, pcSelEpc;

    typedef struct {
        string      nm;
        logic [5:0] exp;
    } item_t;

    item_t      sbq[$];
    item_t      it;
    logic [5:0] act;
    int         total = 0;
    int         bad   = 0;

    // expected {stallF, stallD, clrE, DEMWclr, pcSelExc, pcSelEpc}
    localparam logic [5:0] N  = 6'b000000;
    localparam logic [5:0] L  = 6'b111000;
    localparam logic [5:0] EX = 6'b000110;
    localparam logic [5:0] ER = 6'b000101;

    pipe_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rsD       (rsD),
        .rtD       (rtD),
        .useRsD    (useRsD),
        .useRtD    (useRtD),
        .waE       (waE),
        .memReadE  (memReadE),
        .md_startE (md_startE),
        .md_isdivE (md_isdivE),
        .md_useD   (md_useD),
        .excReqM   (excReqM),
        .eretM     (eretM),
        .stallF    (stallF),
        .stallD    (stallD),
        .clrE      (clrE),
        .DEMWclr   (DEMWclr),
        .pcSelExc  (pcSelExc),
        .pcSelEpc  (pcSelEpc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            it  = sbq.pop_front();
            act = {stallF, stallD, clrE, DEMWclr, pcSelExc, pcSelEpc};
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", it.nm, act, it.exp);
            end
        end
    end

    // md = {md_startE, md_isdivE, md_useD}, er = {excReqM, eretM}
    task automatic step(input string nm, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] wa, input logic mr,
                        input logic [2:0] md, input logic [1:0] er, input logic [5:0] exp);
        @(posedge clk);
        #1;
        rst = r;
        rsD = rs;
        rtD = rt;
        useRsD = urs;
        useRtD = urt;
        waE = wa;
        memReadE = mr;
        {md_startE, md_isdivE, md_useD} = md;
        {excReqM, eretM} = er;
        sbq.push_back('{nm, exp});
    endtask

    initial begin
        step("reset_outputs", 1, 5'd8, 0, 1, 0, 5'd8, 1, 3'b000, 2'b00, N);
        step("idle",          0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, N);
        step("lu_rs",         0, 5'd8, 0, 1, 0, 5'd8, 1, 3'b000, 2'b00, L);
        step("lu_released",   0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, N);
        step("lu_wa_zero",    0, 0, 0, 1, 0, 0, 1, 3'b000, 2'b00, N);
        step("lu_rt",         0, 0, 5'd3, 0, 1, 5'd3, 1, 3'b000, 2'b00, L);
        step("lu_rt_unused",  0, 0, 5'd3, 0, 0, 5'd3, 1, 3'b000, 2'b00, N);
        step("lu_no_load",    0, 5'd8, 0, 1, 0, 5'd8, 0, 3'b000, 2'b00, N);
        step("lu_reg_differ", 0, 5'd9, 0, 1, 0, 5'd8, 1, 3'b000, 2'b00, N);
        step("exc_over_lu",   0, 5'd8, 0, 1, 0, 5'd8, 1, 3'b000, 2'b10, EX);
        step("exc_flush_lu",  0, 5'd8, 0, 1, 0, 5'd8, 1, 3'b000, 2'b00, L);
        step("after_flush",   0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, N);
        step("exc_and_eret",  0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, EX);
        step("eret_alone",    0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b01, ER);
        step("eret_over_lu",  0, 5'd8, 0, 1, 0, 5'd8, 1, 3'b000, 2'b01, ER);
        step("eret_flush",    0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, N);
`ifdef PIPE_CTRL_MDU_STALL_EN
        step("mult_issue", 0, 0, 0, 0, 0, 0, 0, 3'b100, 2'b00, N);
        for (int i = 0; i < 5; i++) step("mult_busy", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, L);
        step("mult_done", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
        step("div_issue", 0, 0, 0, 0, 0, 0, 0, 3'b110, 2'b00, N);
        for (int i = 0; i < 10; i++) step("div_busy", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, L);
        step("div_done", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
        step("issue_use", 0, 0, 0, 0, 0, 0, 0, 3'b101, 2'b00, L);
        for (int i = 0; i < 5; i++) step("mult_drain", 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, N);
        step("mult_idle_use", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
        step("div2_issue", 0, 0, 0, 0, 0, 0, 0, 3'b110, 2'b00, N);
        for (int i = 0; i < 4; i++) step("div2_busy", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, L);
        step("div2_exc", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b10, EX);
        step("div2_flush", 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, N);
        for (int i = 0; i < 4; i++) step("div2_resume", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, L);
        step("div2_done", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
        step("div3_issue", 0, 0, 0, 0, 0, 0, 0, 3'b110, 2'b00, N);
        for (int i = 0; i < 6; i++) step("div3_busy", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, L);
        step("div3_reset", 1, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
        step("div3_released", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
        step("div3_run", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
`else
        step("md_ignored", 0, 0, 0, 0, 0, 0, 0, 3'b111, 2'b00, N);
        for (int i = 0; i < 3; i++) step("md_use_ignored", 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, N);
        step("md_lu_only", 0, 5'd8, 0, 1, 0, 5'd8, 1, 3'b101, 2'b00, L);
`endif
        step("final_idle", 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, N);
        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, mult/multu busy cycles.
REQ-002 SHALL have parameter DIV_CYC, default 10, div/divu busy cycles.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rsD, rtD  in  5 each  D-stage source register numbers.
REQ-006 SHALL have ports useRsD, useRtD  in  1 each  D instruction reads rs/rt before the E stage.
REQ-007 SHALL have ports waE  in  5 and memReadE  in  1  E-stage destination and load flag.
REQ-008 SHALL have ports md_startE  in  1, md_isdivE  in  1, md_useD  in  1  E issues mult/div; E op is div; D uses HI/LO or the MDU.
REQ-009 SHALL have ports excReqM  in  1 and eretM  in  1  exception/interrupt taken at M; eret at M.
REQ-010 SHALL have ports stallF, stallD  out  1 each  hold PC and D register.
REQ-011 SHALL have port clrE  out  1  insert bubble into the E register.
REQ-012 SHALL have port DEMWclr  out  1  flush the D/E/M/W registers; W keeps pc8.
REQ-013 SHALL have ports pcSelExc, pcSelEpc  out  1 each  next PC = 32'h00004180 / EPC.

Function
REQ-014 SHALL implement FSM states RUN, MD_BUSY and EXC_FLUSH.
REQ-015 SHALL compute all outputs combinationally from the state, the busy counter and the current inputs, with no added latency.
REQ-016 SHALL flag a load-use hazard when memReadE=1 && waE!=0 && ((useRsD && rsD==waE) || (useRtD && rtD==waE)).
REQ-017 SHALL, on a load-use hazard, drive stallF=stallD=clrE=1 for exactly the cycles in which the condition holds.
REQ-018 SHALL, on an accepted md_startE, load a busy counter at the next edge with DIV_CYC if md_isdivE=1, else MULT_CYC, and enter MD_BUSY.
REQ-019 SHALL decrement the counter by 1 per cycle and return to RUN on the edge where it reaches 0.
REQ-020 SHALL drive stallF=stallD=clrE=1 while md_useD=1 and (state==MD_BUSY or md_startE=1).
REQ-021 SHALL ignore md_startE while in MD_BUSY (the decoder guarantees no overlap).
REQ-022 SHALL, when excReqM=1, drive DEMWclr=1 and pcSelExc=1, force stallF=stallD=clrE=0, and enter EXC_FLUSH at the next edge.
REQ-023 SHALL, when eretM=1 and excReqM=0, drive DEMWclr=1 and pcSelEpc=1, force stalls to 0, and enter EXC_FLUSH.
REQ-024 SHALL give excReqM priority over eretM, which has priority over MDU stall, which has priority over load-use stall.
REQ-025 SHALL not accept md_startE in the same cycle as excReqM or eretM, because that E instruction is flushed.
REQ-026 SHALL not cancel a busy counter on a flush; if the counter is nonzero, the state after EXC_FLUSH is MD_BUSY, else RUN.
REQ-027 SHALL hold EXC_FLUSH for exactly one cycle, with DEMWclr=0 and stalls evaluated normally.
REQ-028 SHALL use a counter width of clog2(max(MULT_CYC,DIV_CYC)+1) bits and never wrap below 0.

Reset
REQ-029 SHALL, while rst=1, force state=RUN, counter=0, and all outputs to 0, regardless of clk.
REQ-030 SHALL discard an in-flight MDU count if reset is asserted mid-operation; the next cycle after release is RUN with no stall.

Configuration
REQ-031 SHALL, with macro PIPE_CTRL_MDU_STALL_EN defined, implement REQ-018 to REQ-021 and the MD_BUSY state.
REQ-032 SHALL, without PIPE_CTRL_MDU_STALL_EN, omit the counter and MD_BUSY, ignore md_* inputs, and generate stalls from load-use only.

Structure
REQ-033 SHALL take the state encoding, the MULT_CYC/DIV_CYC defaults and the handler address 32'h00004180 from shared package pipe_ctrl_pkg.
REQ-034 SHALL place the busy counter (load, decrement, busy flag) in sub-module md_busy_cnt, instantiated only under PIPE_CTRL_MDU_STALL_EN.

Verification
REQ-035 SHALL verify load-use: memReadE=1, waE=8, useRsD=1, rsD=8 for 1 cycle -> stallF=stallD=clrE=1 that cycle only; waE=0 -> no stall.
REQ-036 SHALL verify mult busy: md_startE=1, md_isdivE=0, then md_useD=1 -> stall for 5 cycles after issue, released when the counter reaches 0; div -> 10 cycles.
REQ-037 SHALL verify exception priority: excReqM=1 with load-use active -> DEMWclr=1, pcSelExc=1, stalls 0, next state EXC_FLUSH, then RUN.
REQ-038 SHALL verify simultaneous excReqM=eretM=1 -> pcSelExc=1, pcSelEpc=0; eretM alone -> pcSelEpc=1, DEMWclr=1.
REQ-039 SHALL verify exception during div with count=6 -> EXC_FLUSH for 1 cycle, then MD_BUSY, counter continues to 0.
REQ-040 SHALL verify async reset asserted mid-div with count=4 -> outputs 0 immediately, state RUN, counter 0 after release.
